// File: rtl/prbs_lfsr_gen_pkg.sv
// Shared constants, types and helpers for the PRBS pattern source.
package prbs_lfsr_gen_pkg;

  localparam int unsigned PRBS_LFSR_MAX_W = 31;
  localparam int unsigned PRBS_DIV_W      = 16;
  localparam logic [PRBS_LFSR_MAX_W-1:0] PRBS_DEFAULT_SEED = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ORD_PRBS7  = 3'd0,
    ORD_PRBS9  = 3'd1,
    ORD_PRBS15 = 3'd2,
    ORD_PRBS23 = 3'd3,
    ORD_PRBS31 = 3'd4
  } prbs_order_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } prbs_state_e;

  // Polynomial order n and second tap t for x^n + x^t + 1.
  typedef struct packed {
    logic [4:0] n;
    logic [4:0] t;
  } prbs_taps_t;

  localparam prbs_taps_t TAPS_PRBS7  = '{n: 5'd7,  t: 5'd6};
  localparam prbs_taps_t TAPS_PRBS9  = '{n: 5'd9,  t: 5'd5};
  localparam prbs_taps_t TAPS_PRBS15 = '{n: 5'd15, t: 5'd14};
  localparam prbs_taps_t TAPS_PRBS23 = '{n: 5'd23, t: 5'd18};
  localparam prbs_taps_t TAPS_PRBS31 = '{n: 5'd31, t: 5'd28};

  // Unused encodings 5-7 fall back to PRBS7.
  function automatic prbs_taps_t order_taps(input logic [2:0] sel);
    prbs_taps_t r;
    case (sel)
      ORD_PRBS9:  r = TAPS_PRBS9;
      ORD_PRBS15: r = TAPS_PRBS15;
      ORD_PRBS23: r = TAPS_PRBS23;
      ORD_PRBS31: r = TAPS_PRBS31;
      default:    r = TAPS_PRBS7;
    endcase
    return r;
  endfunction

  // Low n bits set.
  function automatic logic [PRBS_LFSR_MAX_W-1:0] order_mask(input logic [4:0] n);
    logic [PRBS_LFSR_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PRBS_LFSR_MAX_W; i++) begin
      m[i] = (i < 32'(n));
    end
    return m;
  endfunction

  // Sequence period 2^n-1, which is numerically the n-bit mask.
  function automatic logic [PRBS_LFSR_MAX_W-1:0] period_len(input logic [4:0] n);
    return order_mask(n);
  endfunction

endpackage

// File: rtl/prbs_lfsr_gen_if.sv
// Control and data bundle between the PRBS source and its user.
interface prbs_lfsr_gen_if
  import prbs_lfsr_gen_pkg::*;
#(
  parameter int unsigned DIV_W = PRBS_DIV_W
);
  logic                       prbs_enable;
  logic [2:0]                 prbs_order_sel;
  logic [PRBS_LFSR_MAX_W-1:0] prbs_seed;
  logic [DIV_W-1:0]           prbs_rate_div;
  logic                       prbs_err_inject;
  logic                       prbs_bit_out;
  logic                       lfsr_clk_enable;
  logic                       prbs_seq_start;
  logic                       prbs_busy;
  logic                       prbs_lockup_flag;

  modport master (
    output prbs_enable, prbs_order_sel, prbs_seed, prbs_rate_div, prbs_err_inject,
    input  prbs_bit_out, lfsr_clk_enable, prbs_seq_start, prbs_busy, prbs_lockup_flag
  );

  modport slave (
    input  prbs_enable, prbs_order_sel, prbs_seed, prbs_rate_div, prbs_err_inject,
    output prbs_bit_out, lfsr_clk_enable, prbs_seq_start, prbs_busy, prbs_lockup_flag
  );
endinterface

// File: rtl/prbs_lfsr_gen_rate_divider.sv
// Bit-rate divider: down-counter that ticks at zero and reloads the live rate.
module prbs_rate_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] rate_div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == '0);

  // clear starts a fresh period; reload on tick picks up rate changes at the bit boundary
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = rate_div_i;
    end else if (run_i) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/prbs_lfsr_gen.sv
// Selectable-order Fibonacci PRBS source with rate divider, start marker,
// single-bit error injection and all-zero lock-up recovery.
module prbs_lfsr_gen
  import prbs_lfsr_gen_pkg::*;
#(
  parameter int unsigned                LFSR_MAX_W   = PRBS_LFSR_MAX_W,
  parameter int unsigned                DIV_W        = PRBS_DIV_W,
  parameter logic [LFSR_MAX_W-1:0]      DEFAULT_SEED = PRBS_DEFAULT_SEED
) (
  input  logic           dac_clk,
  input  logic           reset,
  prbs_lfsr_gen_if.slave bus
);
  prbs_state_e           state_q, state_d;
  logic [4:0]            n_q, n_d, tap_q, tap_d;
  logic [LFSR_MAX_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_MAX_W-1:0] idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic                  lock_q, lock_d;
  logic                  bit_q, bit_d;
  logic                  stb_q, stb_d;
  logic                  sos_q, sos_d;
  logic                  busy_q;

  logic                  tick, run_en, load_en, fb, err;
  logic [LFSR_MAX_W-1:0] mask, seed_m;
  prbs_taps_t            sel_taps;

  assign load_en  = (state_q == ST_LOAD) && bus.prbs_enable;
  assign run_en   = (state_q == ST_RUN) && bus.prbs_enable;
  assign mask     = order_mask(n_q);
  assign sel_taps = order_taps(bus.prbs_order_sel);
  assign seed_m   = bus.prbs_seed & order_mask(sel_taps.n);
  assign fb       = lfsr_q[n_q - 5'd1] ^ lfsr_q[tap_q - 5'd1];
  // an inject landing on the tick cycle applies to that tick's bit
  assign err      = pend_q | bus.prbs_err_inject;

  prbs_rate_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i      (dac_clk),
    .rst_i      (reset),
    .clear_i    (load_en),
    .run_i      (run_en),
    .rate_div_i (bus.prbs_rate_div),
    .tick_o     (tick)
  );

  // next state: dropping enable wins over everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.prbs_enable) state_d = ST_LOAD;
      ST_LOAD: state_d = bus.prbs_enable ? ST_RUN : ST_IDLE;
      ST_RUN:  if (!bus.prbs_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // LFSR, bit index, error and output next-state
  always_comb begin
    n_d    = n_q;
    tap_d  = tap_q;
    lfsr_d = lfsr_q;
    idx_d  = idx_q;
    pend_d = pend_q;
    lock_d = lock_q;
    bit_d  = bit_q;
    stb_d  = 1'b0;
    sos_d  = 1'b0;
    if (load_en) begin
      n_d    = sel_taps.n;
      tap_d  = sel_taps.t;
      lfsr_d = (seed_m != '0) ? seed_m : (DEFAULT_SEED & order_mask(sel_taps.n));
      idx_d  = '0;
      lock_d = 1'b0;
      pend_d = 1'b0;
    end else if (run_en) begin
      if (tick) begin
        stb_d  = 1'b1;
        pend_d = 1'b0;
        if ((lfsr_q & mask) == '0) begin
          lfsr_d = DEFAULT_SEED & mask;
          bit_d  = 1'b0;
          lock_d = 1'b1;
          idx_d  = '0;
        end else begin
          lfsr_d = {lfsr_q[LFSR_MAX_W-2:0], fb} & mask;
          bit_d  = fb ^ err;
          sos_d  = (idx_q == '0);
          idx_d  = (idx_q == period_len(n_q) - LFSR_MAX_W'(1)) ? '0 : idx_q + LFSR_MAX_W'(1);
        end
      end else if (bus.prbs_err_inject) begin
        pend_d = 1'b1;
      end
    end else begin
      bit_d  = 1'b0;
      pend_d = 1'b0;
    end
  end

  // datapath and registered outputs
  always_ff @(posedge dac_clk) begin
    if (reset) begin
      n_q    <= '0;
      tap_q  <= '0;
      lfsr_q <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      lock_q <= 1'b0;
      bit_q  <= 1'b0;
      stb_q  <= 1'b0;
      sos_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      tap_q  <= tap_d;
      lfsr_q <= lfsr_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      lock_q <= lock_d;
      bit_q  <= bit_d;
      stb_q  <= stb_d;
      sos_q  <= sos_d;
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.prbs_bit_out     = bit_q;
  assign bus.lfsr_clk_enable  = stb_q;
  assign bus.prbs_seq_start   = sos_q;
  assign bus.prbs_busy        = busy_q;
  assign bus.prbs_lockup_flag = lock_q;
endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Directed and randomized checks of prbs_lfsr_gen against a bit-recurrence model.
module tb_prbs_lfsr_gen;
  localparam int unsigned NONE = 32'hFFFF_FFFF;

  logic dac_clk = 1'b0;
  logic reset;

  prbs_lfsr_gen_if #(.DIV_W(16)) bus ();

  prbs_lfsr_gen #(.DIV_W(16)) dut (
    .dac_clk (dac_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 dac_clk = ~dac_clk;

  int unsigned n_vec, n_err;
  int unsigned m_n, m_t, m_period;
  bit          mq[$];
  int unsigned stb_c[$];
  int unsigned sos_k[$];
  bit          first_bits[$];
  int unsigned inv_cnt;
  logic [6:0]  f7;
  logic [5:0]  f6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge dac_clk);
    #1;
  endtask

  // Output history holds the last n sequence bits; new bit = x[k-n] ^ x[k-t].
  task automatic model_init(input logic [2:0] osel, input logic [30:0] seed);
    logic [30:0] m;
    case (osel)
      3'd1:    begin m_n = 9;  m_t = 5;  end
      3'd2:    begin m_n = 15; m_t = 14; end
      3'd3:    begin m_n = 23; m_t = 18; end
      3'd4:    begin m_n = 31; m_t = 28; end
      default: begin m_n = 7;  m_t = 6;  end
    endcase
    m_period = (32'd1 << m_n) - 32'd1;
    m = seed & m_period[30:0];
    if (m == 31'd0) m = m_period[30:0];
    mq.delete();
    for (int i = int'(m_n) - 1; i >= 0; i--) mq.push_back(m[i]);
  endtask

  task automatic model_next(output bit fb);
    fb = mq[0] ^ mq[m_n - m_t];
    mq.push_back(fb);
    void'(mq.pop_front());
  endtask

  task automatic run_seq(input logic [2:0] osel, input logic [30:0] seed, input int unsigned div0,
                         input int unsigned ncyc, input int unsigned inj_c,
                         input int unsigned chg_c, input int unsigned div1, input bit scramble);
    int unsigned c, next_s, idx, cur_div, nstb;
    bit pend, tick_now, raw, eb, es, last_eb;
    model_init(osel, seed);
    stb_c.delete(); sos_k.delete(); first_bits.delete(); inv_cnt = 0;
    bus.prbs_order_sel = osel;
    bus.prbs_seed      = seed;
    bus.prbs_rate_div  = 16'(div0);
    bus.prbs_enable    = 1'b1;
    cur_div = div0; next_s = div0 + 3; c = 0; idx = 0; pend = 1'b0; nstb = 0; last_eb = 1'b0;
    while (c < ncyc) begin
      bus.prbs_err_inject = (c == inj_c);
      if (c == chg_c) begin
        cur_div = div1;
        bus.prbs_rate_div = 16'(div1);
      end
      if (scramble && c >= 2) begin
        bus.prbs_order_sel = 3'($urandom);
        bus.prbs_seed      = 31'($urandom);
      end
      tick_now = (c + 1 == next_s);
      eb = 1'b0; es = 1'b0; raw = 1'b0;
      if (tick_now) begin
        model_next(raw);
        eb   = raw ^ (pend | (c == inj_c));
        es   = (idx == 0);
        idx  = (idx + 1 == m_period) ? 0 : idx + 1;
        pend = 1'b0;
        next_s = next_s + cur_div + 1;
      end else if (c >= 2 && c == inj_c) begin
        pend = 1'b1;
      end
      step();
      c++;
      chk("strobe", bus.lfsr_clk_enable, tick_now);
      chk("busy", bus.prbs_busy, 1);
      chk("lockup", bus.prbs_lockup_flag, 0);
      if (tick_now) begin
        chk("bit", bus.prbs_bit_out, eb);
        chk("seq_start", bus.prbs_seq_start, es);
        if (bus.prbs_bit_out !== raw) inv_cnt++;
        last_eb = eb;
      end else begin
        chk("bit_hold", bus.prbs_bit_out, last_eb);
        chk("seq_start_quiet", bus.prbs_seq_start, 0);
      end
      if (bus.lfsr_clk_enable === 1'b1) begin
        nstb++;
        stb_c.push_back(c);
        if (bus.prbs_seq_start === 1'b1) sos_k.push_back(nstb);
        if (first_bits.size() < 16) first_bits.push_back(bus.prbs_bit_out);
      end
    end
    bus.prbs_err_inject = 1'b0;
  endtask

  task automatic stop_idle();
    bus.prbs_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.prbs_err_inject = (k == 2);
      step();
      chk("idle_bit", bus.prbs_bit_out, 0);
      chk("idle_strobe", bus.lfsr_clk_enable, 0);
      chk("idle_busy", bus.prbs_busy, 0);
      chk("idle_seq_start", bus.prbs_seq_start, 0);
    end
    bus.prbs_err_inject = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    bus.prbs_enable = 1'b0; bus.prbs_order_sel = 3'd0; bus.prbs_seed = '0;
    bus.prbs_rate_div = '0; bus.prbs_err_inject = 1'b0;
    step(); step();
    chk("reset_bit", bus.prbs_bit_out, 0);
    chk("reset_strobe", bus.lfsr_clk_enable, 0);
    chk("reset_seq_start", bus.prbs_seq_start, 0);
    chk("reset_busy", bus.prbs_busy, 0);
    chk("reset_lockup", bus.prbs_lockup_flag, 0);
    reset = 1'b0;
    step();
    chk("idle_after_reset_busy", bus.prbs_busy, 0);

    // PRBS7, seed 7F, full-rate: 255 strobes span two periods plus one bit
    run_seq(3'd0, 31'h7F, 0, 257, NONE, NONE, 0, 1'b0);
    for (int i = 0; i < 7; i++) f7[6-i] = first_bits[i];
    chk("prbs7_first7", 32'(f7), 32'b0000001);
    chk("prbs7_sos_count", sos_k.size(), 3);
    chk("prbs7_sos_a", sos_k[0], 1);
    chk("prbs7_sos_b", sos_k[1], 128);
    chk("prbs7_sos_c", sos_k[2], 255);
    stop_idle();

    // PRBS15 at rate_div 3: first strobe 4 edges after the LOAD edge, then every 4
    run_seq(3'd2, 31'h1, 3, 60, NONE, NONE, 0, 1'b0);
    chk("prbs15_first_strobe", stb_c[0], 6);
    for (int i = 1; i < stb_c.size(); i++) chk("prbs15_spacing", stb_c[i] - stb_c[i-1], 4);
    stop_idle();

    // PRBS15 full period at full rate: seq_start returns on strobe 32768
    run_seq(3'd2, 31'h5A5A, 0, 32770, NONE, NONE, 0, 1'b0);
    chk("prbs15_sos_count", sos_k.size(), 2);
    chk("prbs15_period", sos_k[1], 32768);
    stop_idle();

    // zero seed falls back to all-ones for PRBS9
    run_seq(3'd1, 31'h0, 1, 80, NONE, NONE, 0, 1'b0);
    for (int i = 0; i < 6; i++) f6[5-i] = first_bits[i];
    chk("prbs9_zero_seed_first6", 32'(f6), 32'b000001);
    stop_idle();

    // inject between ticks inverts exactly the next bit
    run_seq(3'd0, 31'h7F, 3, 40, 7, NONE, 0, 1'b0);
    chk("inject_one_inversion", inv_cnt, 1);
    stop_idle();

    // inject while idle (also pulsed inside stop_idle) is dropped
    run_seq(3'd0, 31'h7F, 3, 40, 0, NONE, 0, 1'b0);
    chk("inject_idle_ignored", inv_cnt, 0);
    stop_idle();

    // rate change 9 -> 1 mid-bit
    run_seq(3'd0, 31'h7F, 9, 40, NONE, 14, 1, 1'b0);
    chk("rate_first_strobe", stb_c[0], 12);
    chk("rate_period_old", stb_c[1] - stb_c[0], 10);
    chk("rate_period_new_a", stb_c[2] - stb_c[1], 2);
    chk("rate_period_new_b", stb_c[3] - stb_c[2], 2);
    stop_idle();

    // reset mid-run, then restart from the seed
    run_seq(3'd0, 31'h7F, 0, 20, NONE, NONE, 0, 1'b0);
    reset = 1'b1;
    step();
    chk("midreset_bit", bus.prbs_bit_out, 0);
    chk("midreset_strobe", bus.lfsr_clk_enable, 0);
    chk("midreset_busy", bus.prbs_busy, 0);
    chk("midreset_seq_start", bus.prbs_seq_start, 0);
    reset = 1'b0;
    run_seq(3'd0, 31'h7F, 0, 20, NONE, NONE, 0, 1'b0);
    chk("restart_sos_first", sos_k[0], 1);
    stop_idle();

    // randomized runs; order/seed scrambled after LOAD must have no effect
    for (int r = 0; r < 8; r++) begin
      logic [2:0]  osel;
      logic [30:0] seed;
      osel = 3'($urandom_range(0, 7));
      seed = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
      run_seq(osel, seed, $urandom_range(0, 4), $urandom_range(60, 160),
              $urandom_range(0, 40), NONE, 0, 1'b1);
      stop_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
